// File: rtl/bw_mul_wb_ctrl.sv
// bw_mul_wb_ctrl: Wishbone classic slave sequencing a combinational
// Baugh-Wooley multiplier. Holds operands, launches an operation on START
// (or on an OPERAND write when AUTO is set), waits SETTLE cycles with the
// multiplier inputs stable, then captures the product and raises DONE.
// Optional feature macro: BW_MUL_IRQ_EN adds irq_o and CTRL.IE (bit2).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no operation in flight, waiting for an accepted start
// ISSUE   | drive mul_a/mul_b from OPERAND, load settle timer, set busy
// WAIT    | settle timer counting down to terminal count 0
// CAPTURE | latch mul_p into RESULT, set DONE, drop busy
module bw_mul_wb_ctrl #(
  parameter int          W         = 8,
  parameter int          SETTLE    = 2,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_n,
  input  logic           wbs_cyc_i,
  input  logic           wbs_stb_i,
  input  logic           wbs_we_i,
  input  logic [3:0]     wbs_sel_i,
  input  logic [31:0]    wbs_adr_i,
  input  logic [31:0]    wbs_dat_i,
  output logic           wbs_ack_o,
  output logic [31:0]    wbs_dat_o,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_p,
  output logic           busy_o
`ifdef BW_MUL_IRQ_EN
  ,
  output logic           irq_o
`endif
);

  localparam int PW = 2 * W;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q;
  logic [PW-1:0] op_q;
  logic [PW-1:0] result_q;
  logic          auto_q;
  logic          done_q;
  logic          err_q;
  logic          ie_q;

  logic          hit, acc, wr, rd;
  logic [1:0]    reg_sel;
  logic          wr_op, wr_ctrl, wr_status, rd_result;
  logic          start_req, start_ok, start_err;
  logic [31:0]   op_merge;
  logic [31:0]   rdata;
  logic          unused_bits;

  // A new hit is only accepted while ack is low, so back-to-back hits
  // alternate accept/ack and each access is acted on exactly once.
  assign hit       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign acc       = hit & ~wbs_ack_o;
  assign wr        = acc & wbs_we_i;
  assign rd        = acc & ~wbs_we_i;
  assign reg_sel   = wbs_adr_i[3:2];
  assign wr_op     = wr && (reg_sel == 2'd0);
  assign wr_ctrl   = wr && (reg_sel == 2'd1);
  assign wr_status = wr && (reg_sel == 2'd2);
  assign rd_result = rd && (reg_sel == 2'd3);

  // Any start request outside IDLE is dropped and flagged as an error.
  assign start_req = (wr_ctrl & wbs_dat_i[0]) | (wr_op & auto_q);
  assign start_ok  = start_req & (state_q == IDLE);
  assign start_err = start_req & (state_q != IDLE);

`ifndef BW_MUL_IRQ_EN
  assign ie_q = 1'b0;
`endif

  assign unused_bits = &{1'b0, wbs_adr_i[1:0], op_merge};

  // Byte-lane merge of write data into the OPERAND register.
  always_comb begin
    op_merge = 32'(op_q);
    for (int b = 0; b < 4; b++) begin
      if (wbs_sel_i[b]) op_merge[8*b +: 8] = wbs_dat_i[8*b +: 8];
    end
  end

  // Read mux for the four registers.
  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd0: rdata = 32'(op_q);
      2'd1: begin
        rdata[1] = auto_q;
        rdata[2] = ie_q;
      end
      2'd2: rdata = {29'b0, err_q, done_q, busy_o};
      default: rdata = 32'(result_q);
    endcase
  end

  // Wishbone acknowledge and read data; data is forced to 0 outside ack.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= acc;
      wbs_dat_o <= rd ? rdata : '0;
    end
  end

  // FSM state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt_q == 4'd0) state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Settle timer: loaded in ISSUE, counts down to terminal count in WAIT.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      cnt_q <= 4'(SETTLE - 1);
    end else if (state_q == WAIT && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Configuration registers: OPERAND, AUTO and (optionally) IE.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      op_q   <= '0;
      auto_q <= 1'b0;
`ifdef BW_MUL_IRQ_EN
      ie_q   <= 1'b0;
`endif
    end else begin
      if (wr_op) op_q <= op_merge[PW-1:0];
      if (wr_ctrl) begin
        auto_q <= wbs_dat_i[1];
`ifdef BW_MUL_IRQ_EN
        ie_q   <= wbs_dat_i[2];
`endif
      end
    end
  end

  // Status flags: capture beats any clear of DONE on the same edge.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == CAPTURE) begin
        done_q <= 1'b1;
      end else if (state_q == ISSUE) begin
        done_q <= 1'b0;
      end else if ((wr_status & wbs_dat_i[1]) | rd_result) begin
        done_q <= 1'b0;
      end
      if (start_err) begin
        err_q <= 1'b1;
      end else if (wr_status & wbs_dat_i[2]) begin
        err_q <= 1'b0;
      end
    end
  end

  // Multiplier drive, busy flag and product capture.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      mul_a    <= '0;
      mul_b    <= '0;
      busy_o   <= 1'b0;
      result_q <= '0;
    end else begin
      if (state_q == ISSUE) begin
        mul_a  <= op_q[W-1:0];
        mul_b  <= op_q[PW-1:W];
        busy_o <= 1'b1;
      end
      if (state_q == CAPTURE) begin
        result_q <= mul_p;
        busy_o   <= 1'b0;
      end
    end
  end

`ifdef BW_MUL_IRQ_EN
  // Interrupt follows DONE & IE one edge later.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) irq_o <= 1'b0;
    else           irq_o <= done_q & ie_q;
  end
`endif

endmodule
